fifo_drain: RTL and testbench

FIFO_DRAIN -- requirements
Module: fifo_drain

---
 rtl/fifo_drain.sv | 186 ++++++++++++++++++
 tb/tb_fifo_drain.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain.sv
// Burst drain engine: pulls words from an upstream FIFO and re-emits them as
// framed bursts (first/last markers) through a 2-entry output queue.
`timescale 1ns/1ps
module fifo_drain #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned BURST_LEN = 8,
   parameter int unsigned TIMEOUT   = 64
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] fifo_data,
   input  logic             fifo_empty,
   input  logic             fifo_almost_full,
   output logic             fifo_pop,
   input  logic             flush,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_first,
   output logic             m_last,
   output logic             busy,
   output logic [15:0]      burst_count,
   output logic             timeout_pulse,
   output logic [1:0]       dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_BURST = 2'd1,
      S_CLOSE = 2'd2
   } state_e;

   typedef struct packed {
      logic             first;
      logic             last;
      logic [WIDTH-1:0] data;
   } entry_t;

   localparam logic [7:0]  BURST_LEN_C    = 8'(BURST_LEN);
   localparam logic [15:0] TIMEOUT_LAST_C = 16'(TIMEOUT - 1);

   state_e           state_q, state_d;
   logic [15:0]      idle_timer_q, idle_timer_d;
   logic [7:0]       popped_q, popped_d;
   logic [WIDTH-1:0] pend_data_q, pend_data_d;
   logic             pend_valid_q, pend_valid_d;
   logic             pend_first_q, pend_first_d;
   entry_t           q0_q, q0_d;
   entry_t           q1_q, q1_d;
   logic [1:0]       outq_count_q, outq_count_d;
   logic [15:0]      burst_count_q, burst_count_d;
   logic             timeout_pulse_q, timeout_pulse_d;

   logic   q_has_room;
   logic   out_fire;
   logic   level_trig;
   logic   start_burst;
   logic   close_fire;
   logic   q_push;
   logic   wr_slot0;
   entry_t push_entry;

   // Output handshake: a word leaves the queue on a cycle where m_valid and
   // m_ready are both high; m_data/m_first/m_last come straight from the
   // queue head register, so they cannot change while the word is unaccepted.
   assign m_valid       = (outq_count_q != 2'd0);
   assign m_data        = q0_q.data;
   assign m_first       = q0_q.first && m_valid;
   assign m_last        = q0_q.last && m_valid;
   assign busy          = (state_q != S_IDLE);
   assign burst_count   = burst_count_q;
   assign timeout_pulse = timeout_pulse_q;
   assign dbg_state     = state_q;

   assign q_has_room  = (outq_count_q != 2'd2);
   assign out_fire    = m_valid && m_ready;
   assign level_trig  = fifo_almost_full || flush;
   assign start_burst = (state_q == S_IDLE) && !fifo_empty &&
                        (level_trig || (idle_timer_q == TIMEOUT_LAST_C));
   assign close_fire  = (state_q == S_CLOSE) && q_has_room;

   // One word is always parked in the pending register so its last flag can
   // be decided later: either the next pop (not last) or CLOSE (last).
   assign fifo_pop = !reset && (state_q == S_BURST) && !fifo_empty &&
                     (popped_q < BURST_LEN_C) && (!pend_valid_q || q_has_room);

   assign q_push   = pend_valid_q && (fifo_pop || close_fire);
   assign wr_slot0 = (outq_count_q == 2'd0) || ((outq_count_q == 2'd1) && out_fire);

   always_comb begin
      push_entry       = '0;
      push_entry.first = pend_first_q;
      push_entry.last  = close_fire;
      push_entry.data  = pend_data_q;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_burst) state_d = S_BURST;
         end
         S_BURST: begin
            if ((popped_q == BURST_LEN_C) || (fifo_empty && (popped_q != 8'd0)))
               state_d = S_CLOSE;
         end
         S_CLOSE: begin
            if (close_fire) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      idle_timer_d    = '0;
      popped_d        = popped_q;
      pend_data_d     = pend_data_q;
      pend_valid_d    = pend_valid_q;
      pend_first_d    = pend_first_q;
      burst_count_d   = burst_count_q;
      timeout_pulse_d = start_burst && !level_trig;

      if ((state_q == S_IDLE) && !fifo_empty && !start_burst)
         idle_timer_d = idle_timer_q + 16'd1;

      if (fifo_pop) begin
         popped_d     = popped_q + 8'd1;
         pend_data_d  = fifo_data;
         pend_valid_d = 1'b1;
         pend_first_d = (popped_q == 8'd0);
      end

      if (close_fire) begin
         popped_d      = '0;
         pend_valid_d  = 1'b0;
         burst_count_d = burst_count_q + 16'd1;
      end
   end

   always_comb begin
      q0_d         = q0_q;
      q1_d         = q1_q;
      outq_count_d = outq_count_q;

      if (out_fire) q0_d = q1_q;
      if (q_push) begin
         if (wr_slot0) q0_d = push_entry;
         else          q1_d = push_entry;
      end

      unique case ({q_push, out_fire})
         2'b10:   outq_count_d = outq_count_q + 2'd1;
         2'b01:   outq_count_d = outq_count_q - 2'd1;
         default: outq_count_d = outq_count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= S_IDLE;
         idle_timer_q    <= '0;
         popped_q        <= '0;
         pend_data_q     <= '0;
         pend_valid_q    <= 1'b0;
         pend_first_q    <= 1'b0;
         q0_q            <= '0;
         q1_q            <= '0;
         outq_count_q    <= '0;
         burst_count_q   <= '0;
         timeout_pulse_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         idle_timer_q    <= idle_timer_d;
         popped_q        <= popped_d;
         pend_data_q     <= pend_data_d;
         pend_valid_q    <= pend_valid_d;
         pend_first_q    <= pend_first_d;
         q0_q            <= q0_d;
         q1_q            <= q1_d;
         outq_count_q    <= outq_count_d;
         burst_count_q   <= burst_count_d;
         timeout_pulse_q <= timeout_pulse_d;
      end
   end

endmodule

// File: tb/tb_fifo_drain.sv
// Directed bench for fifo_drain: behavioural upstream FIFO, scoreboard of
// expected {first,last,data} words, immediate-assertion checks.
`timescale 1ns/1ps
module tb_fifo_drain;

   localparam int W        = 32;
   localparam int AF_LEVEL = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic [W-1:0]  fifo_data;
   logic          fifo_empty;
   logic          fifo_almost_full;
   logic          fifo_pop;
   logic          flush;
   logic          m_valid;
   logic          m_ready;
   logic [W-1:0]  m_data;
   logic          m_first;
   logic          m_last;
   logic          busy;
   logic [15:0]   burst_count;
   logic          timeout_pulse;
   logic [1:0]    dbg_state;

   int            n_checks = 0;
   int            n_err    = 0;
   int            pop_cnt  = 0;
   logic [W+1:0]  exp_q[$];
   logic [W-1:0]  up_q[$];
   logic [W-1:0]  words[8];

   fifo_drain #(.WIDTH(W), .BURST_LEN(8), .TIMEOUT(64)) dut (
      .clk              (clk),
      .reset            (reset),
      .fifo_data        (fifo_data),
      .fifo_empty       (fifo_empty),
      .fifo_almost_full (fifo_almost_full),
      .fifo_pop         (fifo_pop),
      .flush            (flush),
      .m_valid          (m_valid),
      .m_ready          (m_ready),
      .m_data           (m_data),
      .m_first          (m_first),
      .m_last           (m_last),
      .busy             (busy),
      .burst_count      (burst_count),
      .timeout_pulse    (timeout_pulse),
      .dbg_state        (dbg_state)
   );

   always #5 clk = ~clk;

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic update_up();
      fifo_empty       = (up_q.size() == 0);
      fifo_data        = (up_q.size() != 0) ? up_q[0] : '0;
      fifo_almost_full = (up_q.size() >= AF_LEVEL);
   endtask

   task automatic up_push(input logic [W-1:0] d);
      up_q.push_back(d);
      update_up();
   endtask

   task automatic exp_push(input logic first, input logic last, input logic [W-1:0] d);
      exp_q.push_back({first, last, d});
   endtask

   // Drivers act 2 time units after the edge, after the FIFO model's update.
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic wait_bursts(input logic [15:0] target);
      int guard = 0;
      while (burst_count !== target && guard < 300) begin
         tick(1);
         guard++;
      end
      check("burst_count", burst_count, target);
   endtask

   task automatic wait_drain();
      int guard = 0;
      while (exp_q.size() != 0 && guard < 50) begin
         tick(1);
         guard++;
      end
      check("scoreboard_drained", exp_q.size(), 0);
   endtask

   task automatic do_reset(input bit clear_up);
      reset = 1'b1;
      if (clear_up) up_q.delete();
      update_up();
      tick(2);
      check("rst_m_valid", m_valid, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_burst_count", burst_count, 16'd0);
      check("rst_timeout_pulse", timeout_pulse, 1'b0);
      check("rst_first_last", {m_first, m_last}, 2'b00);
      check("rst_state", dbg_state, 2'd0);
      reset = 1'b0;
   endtask

   // Upstream FIFO model: head advances after an edge where fifo_pop was high.
   always begin : up_fifo_model
      logic do_pop;
      logic was_empty;
      @(posedge clk);
      do_pop    = fifo_pop;
      was_empty = fifo_empty;
      #1;
      if (do_pop) begin
         check("pop_nonempty", was_empty, 1'b0);
         if (up_q.size() != 0) begin
            up_q.delete(0);
            pop_cnt++;
         end
         update_up();
      end
   end

   // Output monitor: a word transfers at the coming edge when valid && ready.
   always @(negedge clk) begin
      if (!reset && m_valid && m_ready) begin
         check("word_expected", exp_q.size() != 0, 1'b1);
         if (exp_q.size() != 0)
            check("m_word", {m_first, m_last, m_data}, exp_q.pop_front());
      end
   end

   initial begin
      int base;
      int cyc;
      int guard;
      reset   = 1'b1;
      flush   = 1'b0;
      m_ready = 1'b1;
      update_up();
      tick(1);
      do_reset(1'b1);

      // Almost-full trigger: ten words in, one eight-word burst out.
      for (int i = 0; i < 10; i++) begin
         words[i % 8] = $urandom;
         if (i < 8) exp_push(i == 0, i == 7, words[i % 8]);
         up_push((i < 8) ? words[i % 8] : W'($urandom));
      end
      wait_bursts(16'd1);
      wait_drain();
      check("af_words_left", up_q.size(), 2);
      check("af_idle_after", busy, 1'b0);
      do_reset(1'b1);

      // Timeout trigger: three words, pulse after the idle window.
      for (int i = 0; i < 3; i++) begin
         words[i] = $urandom;
         exp_push(i == 0, i == 2, words[i]);
         up_push(words[i]);
      end
      cyc = 0;
      while (timeout_pulse !== 1'b1 && cyc < 200) begin
         tick(1);
         cyc++;
      end
      // Timer values 0..63 are seen on 64 edges; the pulse register follows.
      check("timeout_latency", cyc, 64);
      check("timeout_busy", busy, 1'b1);
      tick(1);
      check("timeout_one_cycle", timeout_pulse, 1'b0);
      wait_bursts(16'd1);
      wait_drain();

      // One-cycle flush with a single word.
      words[0] = $urandom;
      exp_push(1'b1, 1'b1, words[0]);
      up_push(words[0]);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      check("flush_busy", busy, 1'b1);
      check("flush_no_timeout", timeout_pulse, 1'b0);
      wait_bursts(16'd2);
      wait_drain();

      // Downstream stall mid-burst.
      for (int i = 0; i < 8; i++) begin
         words[i] = $urandom;
         exp_push(i == 0, i == 7, words[i]);
         up_push(words[i]);
      end
      m_ready = 1'b0;
      base    = pop_cnt;
      flush   = 1'b1;
      tick(1);
      flush = 1'b0;
      tick(10);
      check("stall_pops", pop_cnt - base, 3);
      check("stall_no_pop", fifo_pop, 1'b0);
      check("stall_head", {m_valid, m_first, m_last, m_data}, {1'b1, 1'b1, 1'b0, words[0]});
      tick(4);
      check("stall_hold", {m_valid, m_first, m_last, m_data}, {1'b1, 1'b1, 1'b0, words[0]});
      m_ready = 1'b1;
      wait_bursts(16'd3);
      wait_drain();

      // Reset after four of eight words have been popped.
      for (int i = 0; i < 8; i++) begin
         words[i] = $urandom;
         exp_push(i == 0, i == 7, words[i]);
         up_push(words[i]);
      end
      base  = pop_cnt;
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      guard = 0;
      while (pop_cnt - base < 4 && guard < 50) begin
         tick(1);
         guard++;
      end
      check("pops_before_reset", pop_cnt - base, 4);
      reset = 1'b1;
      #1;
      check("reset_forces_no_pop", fifo_pop, 1'b0);
      tick(1);
      check("reset_m_valid", m_valid, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("words_out_before_reset", 8 - exp_q.size(), 2);
      exp_q.delete();
      for (int i = 4; i < 8; i++) exp_push(i == 4, i == 7, words[i]);
      tick(1);
      reset = 1'b0;
      check("left_after_reset", up_q.size(), 4);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      wait_bursts(16'd1);
      wait_drain();

      // Burst counter wrap over 65536 one-word bursts.
      do_reset(1'b1);
      flush = 1'b1;
      for (int i = 0; i < 65536; i++) begin
         exp_push(1'b1, 1'b1, W'(i));
         up_push(W'(i));
         tick(1);
         guard = 0;
         while (busy && guard < 10) begin
            tick(1);
            guard++;
         end
         if (i == 65534) check("burst_count_ffff", burst_count, 16'hFFFF);
      end
      flush = 1'b0;
      check("burst_count_wrap", burst_count, 16'h0000);
      wait_drain();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
